// File: rtl/dvfs_pkg.sv
// Shared DVFS definitions: operating-level encodings and the sequencer state enum
// used by both the V/F sequencer and the load-based policy FSM.
package dvfs_pkg;

  localparam logic [1:0] LVL_LOW     = 2'b00;
  localparam logic [1:0] LVL_NORM    = 2'b01;
  localparam logic [1:0] LVL_HIGH    = 2'b10;
  localparam logic [1:0] LVL_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_V_RAISE = 3'd1,
    ST_F_LOCK  = 3'd2,
    ST_V_LOWER = 3'd3,
    ST_ABORT   = 3'd4
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvfs_settle_timer.sv
// Loadable down-counter shared by the rail-settle and PLL-lock-timeout waits.
// A load sets the count; it then decrements once per cycle and holds at zero.
module dvfs_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dvfs_vf_sequencer.sv
// Orders regulator and PLL level changes so frequency never exceeds what the rail supports:
// voltage up before frequency, frequency down before voltage, with lock-timeout rollback.
module dvfs_vf_sequencer
  import dvfs_pkg::*;
#(
  parameter int VOLT_SETTLE_CYC  = 50,
  parameter int LOCK_TIMEOUT_CYC = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_level,
  output logic       req_ready,
  input  logic       pll_lock,
  output logic       pll_relock,
  output logic [1:0] volt_sel,
  output logic [1:0] freq_sel,
  output logic [1:0] cur_level,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr
);

  localparam int CW = $clog2(max_int(VOLT_SETTLE_CYC, LOCK_TIMEOUT_CYC) + 1);
  // The timer expires one load-value+1 edges after loading, so settle loads S-1
  // and lock timeout loads L (the relock cycle itself is never sampled).
  localparam logic [CW-1:0] SETTLE_LD = CW'(VOLT_SETTLE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LD   = CW'(LOCK_TIMEOUT_CYC);

  seq_state_t    state;
  logic [1:0]    tgt;
  logic [1:0]    old;
  logic          accept;
  logic          raising;
  logic          lock_hit;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_exp;

  assign accept   = req_valid && req_ready;
  assign raising  = (tgt > old);
  assign lock_hit = pll_lock && !pll_relock;
  assign busy     = ~req_ready;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LD;
    case (state)
      ST_IDLE: begin
        if (accept && (req_level != LVL_ILLEGAL) && (req_level != cur_level)) begin
          tmr_load = 1'b1;
          tmr_val  = (req_level > cur_level) ? SETTLE_LD : LOCK_LD;
        end
      end
      ST_V_RAISE: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = LOCK_LD;
        end
      end
      ST_F_LOCK: begin
        if ((lock_hit && !raising) || (!lock_hit && tmr_exp)) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  dvfs_settle_timer #(
    .W(CW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_val),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      volt_sel   <= LVL_NORM;
      freq_sel   <= LVL_NORM;
      cur_level  <= LVL_NORM;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      pll_relock <= 1'b0;
      err        <= 1'b0;
      tgt        <= LVL_NORM;
      old        <= LVL_NORM;
    end else begin
      done       <= 1'b0;
      pll_relock <= 1'b0;
      // Any set below overrides this clear, so a same-cycle set wins.
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tgt <= req_level;
            old <= cur_level;
            if (req_level == LVL_ILLEGAL) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if (req_level == cur_level) begin
              done <= 1'b1;
            end else if (req_level > cur_level) begin
              volt_sel  <= req_level;
              state     <= ST_V_RAISE;
              req_ready <= 1'b0;
            end else begin
              freq_sel   <= req_level;
              pll_relock <= 1'b1;
              state      <= ST_F_LOCK;
              req_ready  <= 1'b0;
            end
          end
        end
        ST_V_RAISE: begin
          if (tmr_exp) begin
            freq_sel   <= tgt;
            pll_relock <= 1'b1;
            state      <= ST_F_LOCK;
          end
        end
        ST_F_LOCK: begin
          if (lock_hit) begin
            if (raising) begin
              cur_level <= tgt;
              done      <= 1'b1;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              volt_sel <= tgt;
              state    <= ST_V_LOWER;
            end
          end else if (tmr_exp) begin
            // Fall back to the old frequency; the rail is still at least that high.
            freq_sel   <= old;
            pll_relock <= 1'b1;
            err        <= 1'b1;
            state      <= ST_ABORT;
          end
        end
        ST_V_LOWER: begin
          if (tmr_exp) begin
            cur_level <= tgt;
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (tmr_exp) begin
            volt_sel  <= old;
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvfs_vf_sequencer.sv
// Directed plus randomized checks of dvfs_vf_sequencer against an offset-timeline model.
module tb_dvfs_vf_sequencer;

  localparam int S     = 4;
  localparam int L     = 8;
  localparam int NEVER = 100000;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_level;
  logic       req_ready;
  logic       pll_lock;
  logic       pll_relock;
  logic [1:0] volt_sel;
  logic [1:0] freq_sel;
  logic [1:0] cur_level;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_clr;

  int         vectors;
  int         miscompares;
  logic [1:0] cur_m;
  logic       err_m;

  dvfs_vf_sequencer #(
    .VOLT_SETTLE_CYC (S),
    .LOCK_TIMEOUT_CYC(L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_level (req_level),
    .req_ready (req_ready),
    .pll_lock  (pll_lock),
    .pll_relock(pll_relock),
    .volt_sel  (volt_sel),
    .freq_sel  (freq_sel),
    .cur_level (cur_level),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_volt"}, {2'b0, volt_sel}, 4'h1);
    chk({tag, "_freq"}, {2'b0, freq_sel}, 4'h1);
    chk({tag, "_cur"}, {2'b0, cur_level}, 4'h1);
    chk({tag, "_ready"}, {3'b0, req_ready}, 4'h1);
    chk({tag, "_busy"}, {3'b0, busy}, 4'h0);
    chk({tag, "_done"}, {3'b0, done}, 4'h0);
    chk({tag, "_relock"}, {3'b0, pll_relock}, 4'h0);
    chk({tag, "_err"}, {3'b0, err}, 4'h0);
  endtask

  // One request from acceptance to done. Lock is available at every edge at
  // offset >= k from the accept edge. While busy, req_valid=nv with level nl.
  task automatic run_req(input logic [1:0] tgt, input int k, input bit clr,
                         input bit nv, input logic [1:0] nl);
    logic [1:0] old, ev, ef, ec;
    logic       erl, eerr, base;
    bit         ill, trivial, raise, success;
    int         tl, a, e_end;
    old     = cur_m;
    ill     = (tgt == 2'b11);
    trivial = ill || (tgt == old);
    raise   = (tgt > old);
    success = 1'b1;
    tl      = 0;
    a       = 0;
    e_end   = 0;
    if (!trivial && raise) begin
      tl      = (k > S + 2) ? k : S + 2;
      a       = S + 1 + L;
      success = (tl <= a);
      e_end   = success ? tl : a + S;
    end else if (!trivial) begin
      tl      = (k > 2) ? k : 2;
      a       = 1 + L;
      success = (tl <= a);
      e_end   = success ? tl + S : a + S;
    end
    base = clr ? 1'b0 : err_m;
    for (int e = 0; e <= e_end; e++) begin
      @(negedge clk);
      req_valid = (e == 0) ? 1'b1 : nv;
      req_level = (e == 0) ? tgt : nl;
      pll_lock  = (e >= k);
      err_clr   = (e == 0) && clr;
      @(posedge clk);
      #1;
      if (trivial) begin
        ev  = old;
        ef  = old;
        erl = 1'b0;
      end else if (raise) begin
        ev  = (!success && e >= e_end) ? old : tgt;
        ef  = (e < S || (!success && e >= a)) ? old : tgt;
        erl = (e == S) || (!success && e == a);
      end else begin
        ev  = (success && e >= tl) ? tgt : old;
        ef  = (!success && e >= a) ? old : tgt;
        erl = (e == 0) || (!success && e == a);
      end
      ec   = (success && !ill && e >= e_end) ? tgt : old;
      eerr = base | ill | (!trivial && !success && e >= a);
      chk("volt_sel", {2'b0, volt_sel}, {2'b0, ev});
      chk("freq_sel", {2'b0, freq_sel}, {2'b0, ef});
      chk("pll_relock", {3'b0, pll_relock}, {3'b0, erl});
      chk("done", {3'b0, done}, {3'b0, (e == e_end)});
      chk("req_ready", {3'b0, req_ready}, {3'b0, (e >= e_end)});
      chk("busy", {3'b0, busy}, {3'b0, (e < e_end)});
      chk("cur_level", {2'b0, cur_level}, {2'b0, ec});
      chk("err", {3'b0, err}, {3'b0, eerr});
      chk("freq_le_volt", {3'b0, (freq_sel <= volt_sel)}, 4'h1);
    end
    err_clr = 1'b0;
    if (success && !ill) cur_m = tgt;
    err_m = base | ill | (!trivial && !success);
  endtask

  initial begin
    logic [1:0] pend, nxt;
    int         mode, k;
    bit         clr, nv;
    vectors     = 0;
    miscompares = 0;
    cur_m       = 2'b01;
    err_m       = 1'b0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_level   = 2'b00;
    pll_lock    = 1'b0;
    err_clr     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("idle");

    // Raise 01->10, lower 10->00, back to 01, then raise with a dead PLL.
    run_req(2'b10, 0, 1'b0, 1'b0, 2'b00);
    run_req(2'b00, 0, 1'b0, 1'b0, 2'b00);
    run_req(2'b01, 0, 1'b0, 1'b0, 2'b00);
    run_req(2'b10, NEVER, 1'b0, 1'b0, 2'b00);

    // Illegal and same-level requests, clear, and set-wins-over-clear.
    run_req(2'b11, 0, 1'b0, 1'b0, 2'b00);
    run_req(2'b01, 0, 1'b1, 1'b0, 2'b00);
    run_req(2'b11, 0, 1'b1, 1'b0, 2'b00);
    run_req(2'b01, 0, 1'b1, 1'b0, 2'b00);

    // A request held during busy must wait, then be taken as ready returns.
    run_req(2'b10, 9, 1'b0, 1'b1, 2'b01);
    run_req(2'b01, 5, 1'b0, 1'b0, 2'b00);

    // Reset in the middle of a voltage raise.
    @(negedge clk);
    req_valid = 1'b1;
    req_level = 2'b10;
    pll_lock  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pre_volt", {2'b0, volt_sel}, 4'h2);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    for (int i = 0; i < S + 3; i++) begin
      @(posedge clk);
      #1;
      chk("midreset_hold_done", {3'b0, done}, 4'h0);
      chk("midreset_hold_freq", {2'b0, freq_sel}, 4'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_m = 2'b01;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("post_reset");

    pend = 2'($urandom_range(0, 3));
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       k = 0;
        1:       k = $urandom_range(2, 12);
        2:       k = NEVER;
        default: k = $urandom_range(0, 20);
      endcase
      clr = ($urandom_range(0, 3) == 0);
      nv  = ($urandom_range(0, 1) == 1);
      nxt = 2'($urandom_range(0, 3));
      run_req(pend, k, clr, nv, nxt);
      pend = nxt;
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dvfs_vf_sequencer.md
# dvfs_vf_sequencer

Sequences voltage and frequency changes for the DVFS power domain so the core is never clocked faster than its rail supports. Sits between the load-based DVFS policy, which issues target operating levels, and the regulator/PLL select lines. Raises voltage before frequency and lowers frequency before voltage. Handles regulator settle delays, the PLL relock handshake, and lock-timeout recovery.

## Interface
Parameters:
- VOLT_SETTLE_CYC, 50, cycles the rail needs to settle after volt_sel changes (≥1)
- LOCK_TIMEOUT_CYC, 200, maximum cycles to wait for pll_lock after a relock (≥2)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  policy presents a target level
- req_level  in  2  target level: 00 low, 01 normal, 10 high, 11 illegal
- req_ready  out  1  sequencer idle; request accepted when req_valid&&req_ready at a rising edge
- pll_lock  in  1  PLL locked indication
- pll_relock  out  1  one-cycle pulse, coincident with every freq_sel change
- volt_sel  out  2  regulator level select (registered)
- freq_sel  out  2  PLL level select (registered)
- cur_level  out  2  last successfully committed level
- busy  out  1  sequence in progress (equals ~req_ready)
- done  out  1  one-cycle pulse when a request completes (success, abort or illegal)
- err  out  1  sticky: illegal request or lock timeout
- err_clr  in  1  clears err; a same-cycle set wins

## Operation
- Reset values: volt_sel=01, freq_sel=01, cur_level=01, req_ready=1, busy=0, done=0, pll_relock=0, err=0, state IDLE, counter 0.
- States: IDLE, V_RAISE, F_LOCK, V_LOWER, ABORT.
- Accept in IDLE: latch tgt=req_level and old=cur_level.
  - tgt==11: set err, pulse done, no output change, remain IDLE.
  - tgt==old: pulse done, no output change, remain IDLE. Back-to-back acceptance is allowed.
  - tgt>old: volt_sel<=tgt, go to V_RAISE.
  - tgt<old: freq_sel<=tgt, pulse pll_relock, go to F_LOCK.
- V_RAISE: count VOLT_SETTLE_CYC, then freq_sel<=tgt, pulse pll_relock, go to F_LOCK.
- F_LOCK: ignore pll_lock in the relock cycle. At the first sampled pll_lock=1:
  - if raising: cur_level<=tgt, done, go to IDLE.
  - if lowering: volt_sel<=tgt, go to V_LOWER.
  - If no lock within LOCK_TIMEOUT_CYC sampled cycles: freq_sel<=old, pulse pll_relock, set err, go to ABORT.
- V_LOWER: count VOLT_SETTLE_CYC, then cur_level<=tgt, done, go to IDLE.
- ABORT: count VOLT_SETTLE_CYC, then volt_sel<=old, done, go to IDLE. cur_level stays old.
  - Restoring lock is not awaited in ABORT; the policy observes err.
- Invariant: freq_sel ≤ volt_sel at every cycle.
- Reset mid-sequence: all outputs return to reset values immediately, and the in-flight request is dropped.

## Timing
Notation: S=VOLT_SETTLE_CYC, L=LOCK_TIMEOUT_CYC, T0=accept edge.
- Raise: volt_sel changes after T0. freq_sel and pll_relock change after T0+S. pll_lock is sampled at edges T0+S+2 onward. At the first edge Tl that samples lock=1, done=1 and req_ready=1 in the following cycle.
- Lower: freq_sel and pll_relock change after T0. Lock is sampled from T0+2. volt_sel changes after Tl. done is pulsed after Tl+S.
- Timeout: if no lock through the edge T_relock+1+L, abort at that edge. The final done comes S cycles later.
- Illegal or same-level request: done after T0, with zero busy cycles.
- Counter width is clog2(max(S,L)+1). The counter reloads on every state entry and never wraps.

## Structure
- Shared package dvfs_pkg holds:
  - level constants LVL_LOW=2'b00, LVL_NORM=2'b01, LVL_HIGH=2'b10, LVL_ILLEGAL=2'b11
  - sequencer state enum, shared with the DVFS policy FSM
- Sub-module dvfs_settle_timer: loadable down-counter with a load input, a value input and an expired flag, reused for settle and lock timeout.

## Test plan
Bench parameters: S=4, L=8.
- Reset, then request 10 with pll_lock held 1 -> volt_sel=10 after T0, freq_sel=10 plus a one-cycle relock after T0+4, done after T0+6, cur_level=10.
- From 10, request 00 with lock held 1 -> freq_sel=00 after T0, volt_sel=00 after T0+2, done after T0+6, freq_sel ≤ volt_sel throughout.
- Request 10 with pll_lock stuck 0 -> ABORT: freq_sel=01 and err=1 after T0+13, volt_sel=01 and done after T0+17, cur_level=01.
- Request 11, then request 01 while at 01 -> each produces a done pulse with no output change; err=1 after the first; err_clr clears err.
- Assert req_valid during busy -> req_ready=0 and the request is not accepted until IDLE; it is accepted in the cycle req_ready returns.
- Assert rst_n=0 in mid-V_RAISE -> all outputs return to reset values asynchronously; no done pulse is issued.
